// File: rtl/guess_game_pkg.sv
// Shared definitions for the memory-game sequencer and its display controller:
// state encodings, digit geometry, LFSR taps and a decimal wrap helper.
package guess_game_pkg;

    localparam logic [2:0] ST_INIT    = 3'b000;
    localparam logic [2:0] ST_SHOW    = 3'b001;
    localparam logic [2:0] ST_ASK     = 3'b010;
    localparam logic [2:0] ST_MATCH   = 3'b011;
    localparam logic [2:0] ST_SUCCESS = 3'b100;

    localparam int NUM_DIGITS  = 5;
    localparam int DIGIT_W     = 4;
    localparam int NUM_OUTPUTS = 8;

    // Fibonacci taps 16,14,13,11 -> register bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [DIGIT_W-1:0] digit_t;

    function automatic digit_t wrap_decimal(input logic [3:0] n);
        return (n >= 4'd10) ? (n - 4'd10) : n;
    endfunction

endpackage

// File: rtl/guess_game_if.sv
// Player-side and display-side signals of the game sequencer, grouped so the
// board top and the display controller share one bundle.
interface guess_game_if;
    import guess_game_pkg::*;

    logic         start_btn;
    logic         confirm_btn;
    logic [3:0]   sw_addr;
    logic [3:0]   sw_val;
    logic [2:0]   state;
    digit_t       data_0;
    digit_t       data_1;
    digit_t       data_2;
    digit_t       data_3;
    digit_t       data_4;
    digit_t       data_5;
    digit_t       data_6;
    digit_t       data_7;

    modport master (
        output start_btn, confirm_btn, sw_addr, sw_val,
        input  state, data_0, data_1, data_2, data_3,
               data_4, data_5, data_6, data_7
    );

    modport slave (
        input  start_btn, confirm_btn, sw_addr, sw_val,
        output state, data_0, data_1, data_2, data_3,
               data_4, data_5, data_6, data_7
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the digit source; advances on
// every clock regardless of game state.
module lfsr16
    import guess_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic        feedback;

    assign feedback  = ^(lfsr_reg & LFSR_TAPS);
    assign lfsr_next = {lfsr_reg[14:0], feedback};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign lfsr = lfsr_reg;

endmodule

// File: rtl/guess_game_fsm.sv
// Round sequencer for the eight-digit memory game: shows five random digits,
// takes an address/guess, runs a timed match and reports. Build option
// GAME_TIMEOUT_EN returns an idle ASK to INIT after TIMEOUT_CYCLES.
module guess_game_fsm
    import guess_game_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES    = 200_000_000,
    parameter int unsigned MATCH_CYCLES   = 100_000_000,
    parameter int unsigned MAX_TRIES      = 3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    guess_game_if.slave  bus
);

    localparam logic [31:0] SHOW_LAST    = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] MATCH_LAST   = 32'(MATCH_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  TRIES_LIMIT  = 4'(MAX_TRIES);
    localparam logic [3:0]  MAX_ADDR     = 4'(NUM_DIGITS - 1);
    localparam logic [2:0]  FILL_DONE    = 3'(NUM_DIGITS);
    localparam int          DATA_BASE    = NUM_OUTPUTS - NUM_DIGITS;

    logic [2:0]  state_reg,  state_next;
    logic [31:0] timer_reg,  timer_next;
    logic [3:0]  tries_reg,  tries_next;
    logic [3:0]  tries_inc;
    logic [2:0]  fill_reg,   fill_next;
    logic [3:0]  addr_reg,   addr_next;
    logic [3:0]  guess_reg,  guess_next;

    digit_t      digit_reg  [NUM_DIGITS];
    digit_t      digit_next [NUM_DIGITS];
    digit_t      data_reg   [NUM_OUTPUTS];
    digit_t      data_next  [NUM_OUTPUTS];
    digit_t      digit_sel;

    logic        start_low_reg;
    logic        confirm_low_reg;
    logic        start_edge;
    logic        confirm_edge;

    logic [15:0] lfsr_value;
    digit_t      lfsr_digit;
    logic        lfsr_unused;

    // The "low" flags reset to 0, so a button held through reset must be
    // seen released before its next rise counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_low_reg   <= 1'b0;
            confirm_low_reg <= 1'b0;
        end else begin
            start_low_reg   <= ~bus.start_btn;
            confirm_low_reg <= ~bus.confirm_btn;
        end
    end

    assign start_edge   = bus.start_btn   & start_low_reg;
    assign confirm_edge = bus.confirm_btn & confirm_low_reg;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr_value)
    );

    assign lfsr_digit  = wrap_decimal(lfsr_value[3:0]);
    assign lfsr_unused = ^lfsr_value[15:4];

    // Digit k is captured during the k-th cycle of SHOW
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_next[gi] = (state_reg == ST_SHOW && fill_reg == 3'(gi))
                              ? lfsr_digit : digit_reg[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                digit_reg[gi] <= '0;
            end else begin
                digit_reg[gi] <= digit_next[gi];
            end
        end
    end

    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (addr_reg == 4'(i)) begin
                digit_sel = digit_reg[i];
            end
        end
    end

    assign tries_inc = tries_reg + 4'd1;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        tries_next = tries_reg;
        fill_next  = fill_reg;
        addr_next  = addr_reg;
        guess_next = guess_reg;

        case (state_reg)
            ST_INIT: begin
                if (start_edge) begin
                    state_next = ST_SHOW;
                    timer_next = '0;
                    tries_next = '0;
                    fill_next  = '0;
                end
            end

            ST_SHOW: begin
                if (fill_reg != FILL_DONE) begin
                    fill_next = fill_reg + 3'd1;
                end
                if (timer_reg == SHOW_LAST) begin
                    state_next = ST_ASK;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end

            ST_ASK: begin
                if (confirm_edge) begin
                    addr_next  = bus.sw_addr;
                    guess_next = bus.sw_val;
                    timer_next = '0;
                    if (bus.sw_addr <= MAX_ADDR) begin
                        state_next = ST_MATCH;
                    end
                end
`ifdef GAME_TIMEOUT_EN
                else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = ST_INIT;
                    tries_next = '0;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
`endif
            end

            ST_MATCH: begin
                if (timer_reg == MATCH_LAST) begin
                    timer_next = '0;
                    if (digit_sel == guess_reg) begin
                        state_next = ST_SUCCESS;
                    end else begin
                        tries_next = tries_inc;
                        state_next = (tries_inc == TRIES_LIMIT) ? ST_INIT : ST_ASK;
                    end
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end

            ST_SUCCESS: begin
                if (start_edge) begin
                    state_next = ST_INIT;
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

`ifndef GAME_TIMEOUT_EN
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT_LAST;
`endif

    // Display values follow the next state so data and state change together
    always_comb begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            data_next[i] = '0;
        end
        case (state_next)
            ST_SHOW: begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    data_next[DATA_BASE + k] = digit_next[k];
                end
            end
            ST_ASK: begin
                data_next[7] = bus.sw_addr;
            end
            ST_SUCCESS: begin
                data_next[7] = addr_next;
                data_next[6] = guess_next;
                data_next[5] = tries_next;
            end
            default: begin
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_data
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg[gi] <= '0;
            end else begin
                data_reg[gi] <= data_next[gi];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
            timer_reg <= '0;
            tries_reg <= '0;
            fill_reg  <= '0;
            addr_reg  <= '0;
            guess_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            tries_reg <= tries_next;
            fill_reg  <= fill_next;
            addr_reg  <= addr_next;
            guess_reg <= guess_next;
        end
    end

    assign bus.state  = state_reg;
    assign bus.data_0 = data_reg[0];
    assign bus.data_1 = data_reg[1];
    assign bus.data_2 = data_reg[2];
    assign bus.data_3 = data_reg[3];
    assign bus.data_4 = data_reg[4];
    assign bus.data_5 = data_reg[5];
    assign bus.data_6 = data_reg[6];
    assign bus.data_7 = data_reg[7];

endmodule

// File: tb/tb_guess_game_fsm.sv
// Scenario bench for guess_game_fsm with short timing parameters; expected
// state/data words are queued as stimulus is applied and popped on sampling.
module tb_guess_game_fsm;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_SHOW    = 3'd1;
    localparam logic [2:0] S_ASK     = 3'd2;
    localparam logic [2:0] S_MATCH   = 3'd3;
    localparam logic [2:0] S_SUCCESS = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [34:0] exp_q [$];
    logic [3:0]  exp_digit [5];
    logic [15:0] model_lfsr;

    guess_game_if bus ();

    guess_game_fsm #(
        .SHOW_CYCLES    (8),
        .MATCH_CYCLES   (4),
        .MAX_TRIES      (2),
        .LFSR_SEED      (16'hACE1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, shift left, feedback into bit 0
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_lfsr <= 16'hACE1;
        else model_lfsr <= {model_lfsr[14:0],
                            model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
    end

    function automatic logic [34:0] vec(input logic [2:0] s, input logic [31:0] d);
        return {s, d};
    endfunction

    function automatic logic [34:0] obs_vec();
        return {bus.state, bus.data_7, bus.data_6, bus.data_5, bus.data_4,
                bus.data_3, bus.data_2, bus.data_1, bus.data_0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [34:0] exp, obs;
        rst_n = 1'b0;
        bus.start_btn = 1'b1;
        bus.confirm_btn = 1'b0;
        bus.sw_addr = 4'd0;
        bus.sw_val = 4'd0;
        for (int k = 0; k < 5; k++) exp_digit[k] = 4'd0;
        repeat (3) tick();
        exp_q.push_back(vec(S_INIT, 32'h0));
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx reset_held state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs, exp); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.confirm_btn = i[0];
            exp_q.push_back(vec(S_INIT, 32'h0));
            tick();
            exp = exp_q.pop_front(); obs = obs_vec(); checks++;
            $display("tx held_start state=%0d data=%h", obs[34:32], obs[31:0]);
            if (obs !== exp) begin failures++; $display("FAIL held_start got=%h exp=%h", obs, exp); end
        end
        bus.start_btn = 1'b0;
        bus.confirm_btn = 1'b0;
        exp_q.push_back(vec(S_INIT, 32'h0));
        tick();
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx start_low state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL start_low got=%h exp=%h", obs, exp); end
    endtask

    // From INIT with start low: fire start, follow SHOW, land in ASK
    task automatic run_show(input string tag);
        logic [34:0] exp, obs;
        logic [31:0] exp_data;
        logic [3:0]  new_d [5];
        logic [3:0]  nib;
        bus.sw_addr = 4'd0;
        exp_data = {exp_digit[4], exp_digit[3], exp_digit[2], exp_digit[1], exp_digit[0], 12'h000};
        bus.start_btn = 1'b1;
        exp_q.push_back(vec(S_SHOW, exp_data));
        tick();
        new_d[0] = 4'(model_lfsr[3:0] % 4'd10);
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx %s show_enter state=%0d data=%h", tag, obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL %s show_enter got=%h exp=%h", tag, obs, exp); end
        bus.start_btn = 1'b0;
        for (int j = 2; j <= 8; j++) begin
            if (j <= 6) exp_data[4*(j+1) +: 4] = new_d[j-2];
            exp_q.push_back(vec(S_SHOW, exp_data));
            tick();
            if (j <= 5) new_d[j-1] = 4'(model_lfsr[3:0] % 4'd10);
            exp = exp_q.pop_front(); obs = obs_vec(); checks++;
            $display("tx %s show_cycle%0d state=%0d data=%h", tag, j, obs[34:32], obs[31:0]);
            if (obs !== exp) begin failures++; $display("FAIL %s show_cycle%0d got=%h exp=%h", tag, j, obs, exp); end
        end
        for (int k = 0; k < 5; k++) begin
            obs = obs_vec();
            nib = obs[4*(k+3) +: 4];
            checks++;
            if (nib > 4'd9) begin failures++; $display("FAIL %s digit%0d_range got=%0d exp=<=9", tag, k, nib); end
            exp_digit[k] = new_d[k];
        end
        exp_q.push_back(vec(S_ASK, 32'h0));
        tick();
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx %s ask_enter state=%0d data=%h", tag, obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL %s ask_enter got=%h exp=%h", tag, obs, exp); end
    endtask

    // Confirm the current switches, then sit out the MATCH phase
    task automatic guess_and_match(input string tag, input logic [34:0] after_match);
        logic [34:0] exp, obs;
        bus.confirm_btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back((i < 4) ? vec(S_MATCH, 32'h0) : after_match);
            tick();
            bus.confirm_btn = 1'b0;
            exp = exp_q.pop_front(); obs = obs_vec(); checks++;
            $display("tx %s match%0d state=%0d data=%h", tag, i, obs[34:32], obs[31:0]);
            if (obs !== exp) begin failures++; $display("FAIL %s match%0d got=%h exp=%h", tag, i, obs, exp); end
        end
    endtask

    task automatic test_invalid_addr();
        logic [34:0] exp, obs;
        run_show("first");
        bus.sw_addr = 4'd6;
        bus.sw_val = 4'd3;
        bus.confirm_btn = 1'b1;
        bus.start_btn = 1'b1;
        exp_q.push_back(vec(S_ASK, 32'h6000_0000));
        tick();
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx bad_addr state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL bad_addr got=%h exp=%h", obs, exp); end
        bus.confirm_btn = 1'b0;
        bus.start_btn = 1'b0;
        bus.sw_addr = 4'd2;
        bus.sw_val = exp_digit[2];
        exp_q.push_back(vec(S_ASK, 32'h2000_0000));
        tick();
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx addr_live state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL addr_live got=%h exp=%h", obs, exp); end
        guess_and_match("good", vec(S_SUCCESS, {4'd2, exp_digit[2], 4'd0, 20'h0}));
        exp_q.push_back(vec(S_SUCCESS, {4'd2, exp_digit[2], 4'd0, 20'h0}));
        tick();
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx success_hold state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL success_hold got=%h exp=%h", obs, exp); end
        bus.start_btn = 1'b1;
        exp_q.push_back(vec(S_INIT, 32'h0));
        tick();
        bus.start_btn = 1'b0;
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx success_exit state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL success_exit got=%h exp=%h", obs, exp); end
        tick();
    endtask

    task automatic test_retry();
        logic [34:0] exp, obs;
        run_show("retry");
        bus.sw_addr = 4'd1;
        bus.sw_val = 4'((exp_digit[1] + 4'd1) % 4'd10);
        guess_and_match("wrong1", vec(S_ASK, 32'h1000_0000));
        bus.sw_val = exp_digit[1];
        guess_and_match("right", vec(S_SUCCESS, {4'd1, exp_digit[1], 4'd1, 20'h0}));
        bus.start_btn = 1'b1;
        exp_q.push_back(vec(S_INIT, 32'h0));
        tick();
        bus.start_btn = 1'b0;
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx retry_exit state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL retry_exit got=%h exp=%h", obs, exp); end
        tick();
    endtask

    task automatic test_abort();
        logic [34:0] exp, obs;
        run_show("abort");
        bus.sw_addr = 4'd4;
        bus.sw_val = 4'((exp_digit[4] + 4'd3) % 4'd10);
        guess_and_match("abort1", vec(S_ASK, 32'h4000_0000));
        guess_and_match("abort2", vec(S_INIT, 32'h0));
        exp_q.push_back(vec(S_INIT, 32'h0));
        tick();
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx abort_stay state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL abort_stay got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_reset_mid();
        logic [34:0] exp, obs;
        run_show("midrst");
        bus.sw_addr = 4'd0;
        bus.sw_val = exp_digit[0];
        bus.confirm_btn = 1'b1;
        exp_q.push_back(vec(S_MATCH, 32'h0));
        tick();
        bus.confirm_btn = 1'b0;
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx midrst_match state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL midrst_match got=%h exp=%h", obs, exp); end
        #2;
        rst_n = 1'b0;
        exp_q.push_back(vec(S_INIT, 32'h0));
        #1;
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx rst_async state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL rst_async got=%h exp=%h", obs, exp); end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(vec(S_INIT, 32'h0));
            tick();
            exp = exp_q.pop_front(); obs = obs_vec(); checks++;
            $display("tx rst_hold state=%0d data=%h", obs[34:32], obs[31:0]);
            if (obs !== exp) begin failures++; $display("FAIL rst_hold got=%h exp=%h", obs, exp); end
        end
        for (int k = 0; k < 5; k++) exp_digit[k] = 4'd0;
        rst_n = 1'b1;
        exp_q.push_back(vec(S_INIT, 32'h0));
        tick();
        exp = exp_q.pop_front(); obs = obs_vec(); checks++;
        $display("tx rst_release state=%0d data=%h", obs[34:32], obs[31:0]);
        if (obs !== exp) begin failures++; $display("FAIL rst_release got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_timeout();
        logic [34:0] exp, obs;
        run_show("timeout");
        for (int i = 1; i <= 16; i++) begin
`ifdef GAME_TIMEOUT_EN
            exp_q.push_back((i < 16) ? vec(S_ASK, 32'h0) : vec(S_INIT, 32'h0));
`else
            exp_q.push_back(vec(S_ASK, 32'h0));
`endif
            tick();
            exp = exp_q.pop_front(); obs = obs_vec(); checks++;
            $display("tx idle%0d state=%0d data=%h", i, obs[34:32], obs[31:0]);
            if (obs !== exp) begin failures++; $display("FAIL idle%0d got=%h exp=%h", i, obs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_invalid_addr();
        test_retry();
        test_abort();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
